// File: rtl/pending_req_arbiter.sv
// Collects rising edges on 32 request lines into a sticky pending vector and
// presents one eligible request at a time (fixed priority or round-robin).
module pending_req_arbiter #(
    parameter int unsigned RR_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_in,
    input  logic [31:0] mask,
    output logic [4:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pending,
    output logic [5:0]  pend_cnt,
    output logic        drop
);

    // Handshake: a request is transferred in a cycle where out_valid and
    // out_ready are both 1; once out_valid rises, out_idx holds until then.
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_prev_q;
    logic [31:0] pending_q, pending_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        drop_q, drop_d;
    logic [4:0]  out_idx_q;
    logic [4:0]  last_idx_q;
    logic [31:0] edge_v, clr_v, eligible;
    logic [4:0]  sel_idx;
    logic [4:0]  cand;
    logic        accept;

    assign accept   = (state_q == PRESENT) && out_ready;
    assign edge_v   = req_in & ~req_prev_q;
    assign clr_v    = accept ? (32'd1 << out_idx_q) : 32'd0;
    assign eligible = pending_q & ~mask;

    // A new edge on the bit being cleared wins, so it is ORed in after the clear.
    always_comb begin
        pending_d = (pending_q & ~clr_v) | edge_v;
        drop_d    = |(edge_v & pending_q & ~clr_v);
        cnt_d     = '0;
        for (int i = 0; i < 32; i++) begin
            cnt_d = cnt_d + 6'(pending_d[i]);
        end
    end

    // Round-robin walks downward from last_idx-1; k = 32 wraps to last_idx itself,
    // and later iterations overwrite earlier ones, so the smallest k wins.
    always_comb begin
        sel_idx = '0;
        cand    = '0;
        if (RR_MODE != 0) begin
            for (int k = 32; k >= 1; k--) begin
                cand = last_idx_q - 5'(k);
                if (eligible[cand]) sel_idx = cand;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (eligible[i]) sel_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (eligible != 32'd0) state_d = PRESENT;
            PRESENT: if (out_ready)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == PRESENT);
        out_idx   = out_idx_q;
        pending   = pending_q;
        pend_cnt  = cnt_q;
        drop      = drop_q;
    end

    // req_prev tracks req_in even in reset so held-high lines raise nothing.
    always_ff @(posedge clk) begin
        req_prev_q <= req_in;
        if (rst) begin
            pending_q  <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            out_idx_q  <= '0;
            last_idx_q <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            if (state_q == IDLE && eligible != 32'd0) out_idx_q <= sel_idx;
            if (accept) last_idx_q <= out_idx_q;
        end
    end

endmodule
